uart_transmitter: RTL and testbench

//   Serialises bytes into 8N1 UART frames on uart_tx: start bit 0, 8 data bits, stop bit 1.
//   Bit boundaries are paced by baud_rate_signal from baud_rate_generator, shared with uart_receiver.
//   A small input FIFO decouples the byte producer from the line.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_transmitter.sv | 119 +++++++++++
 tb/tb_uart_transmitter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame size and the transmitter/receiver state encoding.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam logic UART_IDLE      = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Bit presented on the line from the current shift register contents.
    function automatic logic tx_bit(input logic [UART_DATA_BITS-1:0] sr, input bit msb_first);
        return msb_first ? sr[UART_DATA_BITS-1] : sr[0];
    endfunction

    function automatic logic [UART_DATA_BITS-1:0] tx_shift(input logic [UART_DATA_BITS-1:0] sr,
                                                           input bit msb_first);
        return msb_first ? {sr[UART_DATA_BITS-2:0], 1'b0} : {1'b0, sr[UART_DATA_BITS-1:1]};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through read data and a registered full flag.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    // A write is refused while full even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: FIFO-buffered bytes are framed and shifted out, one bit per baud tick.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       baud_rate_signal,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      tx_q, tx_d;
    logic                      done_q, done_d;
    logic                      pop;
    logic [7:0]                fifo_rd;
    logic                      fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i     (clk_in),
        .rst_i     (rst),
        .push_i    (tx_valid),
        .wr_data_i (tx_data),
        .pop_i     (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        if (baud_rate_signal) begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_rd;
                        bit_cnt_d = '0;
                        tx_d      = UART_START_BIT;
                        state_d   = START;
                    end
                end
                START: begin
                    tx_d    = tx_bit(shift_q, MSB_FIRST);
                    shift_d = tx_shift(shift_q, MSB_FIRST);
                    state_d = DATA;
                end
                DATA: begin
                    // bit_cnt counts data bits already launched after the first one.
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d    = UART_STOP_BIT;
                        state_d = STOP;
                    end else begin
                        tx_d      = tx_bit(shift_q, MSB_FIRST);
                        shift_d   = tx_shift(shift_q, MSB_FIRST);
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_rd;
                        bit_cnt_d = '0;
                        tx_d      = UART_START_BIT;
                        state_d   = START;
                    end else begin
                        tx_d    = UART_IDLE;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign uart_tx    = tx_q;
    assign frame_done = done_q;
    assign tx_ready   = !fifo_full;
    assign tx_busy    = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: LSB-first and MSB-first instances share one stimulus and a frame-level model.
module tb_uart_transmitter;

    localparam int BAUD  = 20;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rdy0, tx0, busy0, fd0;
    logic       rdy1, tx1, busy1, fd1;
    int         cyc = 0;
    bit         tick_en = 1'b1;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         fd_cnt = 0;

    // Frame-level model: queue of accepted bytes, byte on the line, bit position within its frame.
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         pos = -1;
    logic       exp_fd = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign baud_tick = tick_en && ((cyc % BAUD) == BAUD - 1);

    uart_transmitter #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_in(clk), .rst(rst), .baud_rate_signal(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy0), .uart_tx(tx0), .tx_busy(busy0), .frame_done(fd0));

    uart_transmitter #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk_in(clk), .rst(rst), .baud_rate_signal(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy1), .uart_tx(tx1), .tx_busy(busy1), .frame_done(fd1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out at t=%0t", nm, $time);
    endtask

    // Frame position 0 is the start bit, 1..8 data bits in send order, 9 the stop bit.
    function automatic logic line_bit(input int p, input logic [7:0] b, input bit msb);
        if (p < 0 || p == 9) return 1'b1;
        if (p == 0) return 1'b0;
        return msb ? b[8 - p] : b[p - 1];
    endfunction

    initial begin
        bit         s_rst, s_tick, s_v, rdy_before, exp_rdy, exp_busy;
        logic [7:0] s_d;
        forever begin
            @(posedge clk);
            s_rst = rst; s_tick = baud_tick; s_v = tx_valid; s_d = tx_data;
            if (s_rst) begin
                q.delete();
                pos    = -1;
                exp_fd = 1'b0;
            end else begin
                rdy_before = (q.size() < DEPTH);
                exp_fd     = 1'b0;
                if (s_tick) begin
                    if (pos < 0 || pos == 9) begin
                        if (pos == 9) exp_fd = 1'b1;
                        if (q.size() > 0) begin
                            cur = q.pop_front();
                            pos = 0;
                        end else begin
                            pos = -1;
                        end
                    end else begin
                        pos++;
                    end
                end
                if (s_v && rdy_before) q.push_back(s_d);
            end
            exp_rdy  = (q.size() < DEPTH);
            exp_busy = (pos >= 0) || (q.size() > 0);
            #1;
            if (fd0 === 1'b1) fd_cnt++;
            if (chk_en && !rst) begin
                chk("line_lsb", tx0, line_bit(pos, cur, 1'b0));
                chk("line_msb", tx1, line_bit(pos, cur, 1'b1));
                chk("tx_ready", rdy0, exp_rdy);
                chk("tx_ready_msb", rdy1, exp_rdy);
                chk("tx_busy", busy0, exp_busy);
                chk("tx_busy_msb", busy1, exp_busy);
                chk("frame_done", fd0, exp_fd);
                chk("frame_done_msb", fd1, exp_fd);
            end
        end
    end

    // Holds the byte until accepted; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] d, output int waited);
        waited = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        while (rdy0 !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) timeout("send_byte");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy0 !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeout("wait_idle");
        repeat (3) @(negedge clk);
    endtask

    // Samples both lines at mid-bit for one frame, starting from the next start bit.
    task automatic capture(output logic [9:0] l0, output logic [9:0] l1, output int start_cyc);
        int n = 0;
        while (tx0 !== 1'b0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) timeout("capture_start");
        start_cyc = cyc;
        repeat (BAUD / 2) @(posedge clk);
        #1;
        for (int i = 9; i >= 0; i--) begin
            l0[i] = tx0;
            l1[i] = tx1;
            if (i > 0) begin
                repeat (BAUD) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [9:0] l0, l1, m0, m1;
        int         w, s1, s2, n, fd_before;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", tx0, 1'b1);
        chk("rst_tx_ready", rdy0, 1'b1);
        chk("rst_tx_busy", busy0, 1'b0);
        chk("rst_frame_done", fd0, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        fd_before = fd_cnt;
        send_byte(8'hA5, w);
        capture(l0, l1, s1);
        chk("a5_lsb_frame", l0, 10'b0101001011);
        chk("a5_msb_frame", l1, 10'b0101001011);
        wait_idle();
        chk("a5_one_frame_done", fd_cnt - fd_before, 1);

        send_byte(8'h01, w);
        capture(l0, l1, s1);
        chk("x01_lsb_frame", l0, 10'b0100000001);
        chk("x01_msb_frame", l1, 10'b0000000011);
        wait_idle();

        send_byte(8'h00, w);
        send_byte(8'hFF, w);
        capture(l0, l1, s1);
        capture(m0, m1, s2);
        chk("b2b_first", l0, 10'b0000000001);
        chk("b2b_second", m0, 10'b0111111111);
        chk("b2b_no_gap", s2 - s1, 10 * BAUD);
        wait_idle();

        send_byte(8'h81, w);
        capture(l0, l1, s1);
        chk("x81_msb_frame", l1, 10'b0100000011);
        wait_idle();

        // Byte written on the tick edge itself must wait for the following tick.
        n = 0;
        @(negedge clk);
        while (baud_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        n = 1;
        while (tx0 !== 1'b0 && n < 3 * BAUD) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tick_push_delay", n, BAUD + 1);
        wait_idle();

        send_byte(8'h11, w);
        n = 0;
        while (tx0 !== 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        send_byte(8'h22, w);
        send_byte(8'h33, w);
        send_byte(8'h44, w);
        send_byte(8'h55, w);
        @(negedge clk);
        chk("full_ready_low", rdy0, 1'b0);
        send_byte(8'h66, w);
        chk("fifth_byte_held", (w > 0), 1'b1);
        wait_idle();

        @(negedge clk);
        tick_en = 1'b0;
        send_byte(8'h9E, w);
        send_byte(8'h47, w);
        repeat (50) @(negedge clk);
        chk("no_tick_line_idle", tx0, 1'b1);
        chk("no_tick_busy", busy0, 1'b1);
        chk("no_tick_ready", rdy0, 1'b1);
        tick_en = 1'b1;
        wait_idle();

        send_byte(8'hC3, w);
        send_byte(8'h5A, w);
        send_byte(8'h7E, w);
        repeat (3 * BAUD) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midframe_rst_line", tx0, 1'b1);
        chk("midframe_rst_line_msb", tx1, 1'b1);
        chk("midframe_rst_ready", rdy0, 1'b1);
        chk("midframe_rst_busy", busy0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * BAUD) @(negedge clk);
        chk("post_rst_fifo_empty", busy0, 1'b0);
        chk("post_rst_line", tx0, 1'b1);

        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
            send_byte(8'($urandom), w);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
